// File: rtl/data_store.sv
// data_store: round-robin R/G/B word collector feeding a 2-entry FIFO.
// Each buffered word carries its target word address. The address wraps at
// ADDR_MAX, and frame_done pulses once when the last word of a frame is popped.
module data_store #(
    parameter int                ADDR_W   = 17,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 17'd76799
) (
    input  logic              clk,
    input  logic              rst_,
    input  logic              en,
    input  logic [31:0]       r_data,
    input  logic              r_rts,
    output logic              r_rtr,
    input  logic [31:0]       g_data,
    input  logic              g_rts,
    output logic              g_rtr,
    input  logic [31:0]       b_data,
    input  logic              b_rts,
    output logic              b_rtr,
    output logic [31:0]       out_data,
    output logic              out_rts,
    input  logic              out_rtr,
    output logic [ADDR_W-1:0] mem_ptr,
    output logic              frame_done
);

    typedef enum logic [1:0] {
        SEL_R = 2'd0,
        SEL_G = 2'd1,
        SEL_B = 2'd2
    } sel_e;

    sel_e              sel_q, sel_d;
    logic [1:0]        count_q, count_d;
    logic [31:0]       head_data_q, head_data_d;   // drives out_data
    logic [ADDR_W-1:0] head_addr_q, head_addr_d;   // drives mem_ptr
    logic [31:0]       tail_data_q, tail_data_d;
    logic [ADDR_W-1:0] tail_addr_q, tail_addr_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              out_rts_q, out_rts_d;
    logic              frame_done_q, frame_done_d;

    logic              room_s;
    logic              sel_rts_s;
    logic [31:0]       sel_data_s;
    logic              push_s;
    logic              pop_s;

    // Next channel in the fixed R -> G -> B -> R rotation.
    function automatic sel_e next_sel(input sel_e cur);
        case (cur)
            SEL_R:   next_sel = SEL_G;
            SEL_G:   next_sel = SEL_B;
            SEL_B:   next_sel = SEL_R;
            default: next_sel = SEL_R;
        endcase
    endfunction

    assign room_s = (count_q != 2'd2);
    assign r_rtr  = (sel_q == SEL_R) & room_s & ~en;
    assign g_rtr  = (sel_q == SEL_G) & room_s & ~en;
    assign b_rtr  = (sel_q == SEL_B) & room_s & ~en;

    // Route the currently selected producer to the FIFO write port.
    always_comb begin
        sel_rts_s  = 1'b0;
        sel_data_s = 32'd0;
        case (sel_q)
            SEL_R: begin
                sel_rts_s  = r_rts;
                sel_data_s = r_data;
            end
            SEL_G: begin
                sel_rts_s  = g_rts;
                sel_data_s = g_data;
            end
            SEL_B: begin
                sel_rts_s  = b_rts;
                sel_data_s = b_data;
            end
            default: begin
                sel_rts_s  = 1'b0;
                sel_data_s = 32'd0;
            end
        endcase
    end

    assign push_s = sel_rts_s & room_s & ~en;
    assign pop_s  = (count_q != 2'd0) & out_rtr;

    // Next-state logic for the FIFO, address counter, channel select and frame pulse.
    always_comb begin
        sel_d        = sel_q;
        count_d      = count_q;
        head_data_d  = head_data_q;
        head_addr_d  = head_addr_q;
        tail_data_d  = tail_data_q;
        tail_addr_d  = tail_addr_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        if (en) begin
            // Restart: drop buffered words but leave out_data/mem_ptr as they were.
            sel_d     = SEL_R;
            count_d   = 2'd0;
            wr_addr_d = {ADDR_W{1'b0}};
        end else begin
            frame_done_d = pop_s & (head_addr_q == ADDR_MAX);
            if (push_s) begin
                sel_d = next_sel(sel_q);
                if (wr_addr_q == ADDR_MAX) begin
                    wr_addr_d = {ADDR_W{1'b0}};
                end else begin
                    wr_addr_d = wr_addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end else begin
                wr_addr_d = wr_addr_q;
            end
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_data_d = sel_data_s;
                        head_addr_d = wr_addr_q;
                    end else begin
                        tail_data_d = sel_data_s;
                        tail_addr_d = wr_addr_q;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    if (count_q == 2'd2) begin
                        head_data_d = tail_data_q;
                        head_addr_d = tail_addr_q;
                    end else begin
                        head_data_d = head_data_q;
                        head_addr_d = head_addr_q;
                    end
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable with count==1: the new word replaces the departing head.
                    head_data_d = sel_data_s;
                    head_addr_d = wr_addr_q;
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
        out_rts_d = (count_d != 2'd0);
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sel_q        <= SEL_R;
            count_q      <= 2'd0;
            head_data_q  <= 32'd0;
            head_addr_q  <= {ADDR_W{1'b0}};
            tail_data_q  <= 32'd0;
            tail_addr_q  <= {ADDR_W{1'b0}};
            wr_addr_q    <= {ADDR_W{1'b0}};
            out_rts_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_addr_q  <= head_addr_d;
            tail_data_q  <= tail_data_d;
            tail_addr_q  <= tail_addr_d;
            wr_addr_q    <= wr_addr_d;
            out_rts_q    <= out_rts_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign out_data   = head_data_q;
    assign mem_ptr    = head_addr_q;
    assign out_rts    = out_rts_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_data_store.sv
// tb_data_store: table-driven directed vectors, hand-written restart and
// async-reset sequences, and randomized traffic checked against a queue model.
module tb_data_store;

    localparam int          AW   = 17;
    localparam logic [16:0] AMAX = 17'd5;
    localparam logic [31:0] DR   = 32'h11111111;
    localparam logic [31:0] DG   = 32'h22222222;
    localparam logic [31:0] DB   = 32'h33333333;

    logic          clk = 1'b0;
    logic          rst_ = 1'b0;
    logic          en = 1'b0;
    logic [31:0]   r_data = 32'd0, g_data = 32'd0, b_data = 32'd0;
    logic          r_rts = 1'b0, g_rts = 1'b0, b_rts = 1'b0;
    logic          r_rtr, g_rtr, b_rtr;
    logic [31:0]   out_data;
    logic          out_rts;
    logic          out_rtr = 1'b0;
    logic [AW-1:0] mem_ptr;
    logic          frame_done;

    data_store #(.ADDR_W(AW), .ADDR_MAX(AMAX)) dut (
        .clk(clk), .rst_(rst_), .en(en),
        .r_data(r_data), .r_rts(r_rts), .r_rtr(r_rtr),
        .g_data(g_data), .g_rts(g_rts), .g_rtr(g_rtr),
        .b_data(b_data), .b_rts(b_rts), .b_rtr(b_rtr),
        .out_data(out_data), .out_rts(out_rts), .out_rtr(out_rtr),
        .mem_ptr(mem_ptr), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of {data, addr}, channel index 0/1/2 = R/G/B.
    typedef struct packed {
        logic [31:0] d;
        logic [16:0] a;
    } ent_t;

    ent_t        q[$];
    int          m_sel;
    int          m_wr;
    logic [31:0] m_data;
    logic [16:0] m_ptr;
    logic        m_fd;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_sel  = 0;
        m_wr   = 0;
        m_data = 32'd0;
        m_ptr  = 17'd0;
        m_fd   = 1'b0;
    endtask

    task automatic do_reset();
        rst_ = 1'b0; en = 1'b0; out_rtr = 1'b0;
        r_rts = 1'b0; g_rts = 1'b0; b_rts = 1'b0;
        model_reset();
        #1;
        chk("reset_rtr", {61'd0, r_rtr, g_rtr, b_rtr}, 64'd4);
        chk("reset_out", {out_rts, frame_done, out_data, 13'd0, mem_ptr}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    // One clock cycle: drive at the negedge, check rtrs before the edge and
    // registered outputs just after it, update the model, return at the next negedge.
    task automatic cycle(input logic [2:0] rts, input logic e, input logic ortr,
                         input logic [31:0] rd, input logic [31:0] gd, input logic [31:0] bd,
                         output logic [2:0] rtr_seen);
        logic [2:0]  er;
        logic        push;
        logic        pop;
        logic [31:0] pd;
        r_rts = rts[2]; g_rts = rts[1]; b_rts = rts[0];
        en = e; out_rtr = ortr;
        r_data = rd; g_data = gd; b_data = bd;
        #1;
        er = 3'b000;
        if (q.size() < 2 && !e) er[2 - m_sel] = 1'b1;
        rtr_seen = {r_rtr, g_rtr, b_rtr};
        chk("rtr", {61'd0, rtr_seen}, {61'd0, er});
        push = |(er & rts);
        pop  = (q.size() != 0) && ortr;
        pd   = (m_sel == 0) ? rd : (m_sel == 1) ? gd : bd;
        @(posedge clk);
        #1;
        if (e) begin
            q.delete();
            m_wr  = 0;
            m_sel = 0;
            m_fd  = 1'b0;
        end else begin
            m_fd = pop && (q[0].a == AMAX);
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back('{d: pd, a: 17'(m_wr)});
                m_wr  = (m_wr == int'(AMAX)) ? 0 : m_wr + 1;
                m_sel = (m_sel + 1) % 3;
            end
        end
        if (q.size() != 0) begin
            m_data = q[0].d;
            m_ptr  = q[0].a;
        end
        chk("out_rts", {63'd0, out_rts}, {63'd0, (q.size() != 0)});
        chk("out_data", {32'd0, out_data}, {32'd0, m_data});
        chk("mem_ptr", {47'd0, mem_ptr}, {47'd0, m_ptr});
        chk("frame_done", {63'd0, frame_done}, {63'd0, m_fd});
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst;
        logic [2:0]  rts;
        logic        ortr;
        logic [2:0]  ertr;
        logic        eors;
        logic [31:0] edata;
        logic [16:0] eptr;
        logic        efd;
    } vec_t;

    vec_t tbl[18];

    initial begin
        logic [2:0] seen;
        // Basic order, wrap at ADDR_MAX=5 and frame_done.
        tbl[0]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, DR, 17'd0, 1'b0};
        tbl[1]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, DG, 17'd1, 1'b0};
        tbl[2]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, DB, 17'd2, 1'b0};
        tbl[3]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, DR, 17'd3, 1'b0};
        tbl[4]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, DG, 17'd4, 1'b0};
        tbl[5]  = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, DB, 17'd5, 1'b0};
        tbl[6]  = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, DR, 17'd0, 1'b1};
        tbl[7]  = '{1'b0, 3'b111, 1'b1, 3'b010, 1'b1, DG, 17'd1, 1'b0};
        // Order enforcement: G/B requests ignored until R transfers.
        tbl[8]  = '{1'b1, 3'b011, 1'b1, 3'b100, 1'b0, 32'd0, 17'd0, 1'b0};
        tbl[9]  = '{1'b0, 3'b011, 1'b1, 3'b100, 1'b0, 32'd0, 17'd0, 1'b0};
        tbl[10] = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, DR, 17'd0, 1'b0};
        tbl[11] = '{1'b0, 3'b011, 1'b1, 3'b010, 1'b1, DG, 17'd1, 1'b0};
        // Backpressure: two accepts, rtr drops, then release.
        tbl[12] = '{1'b1, 3'b111, 1'b0, 3'b100, 1'b1, DR, 17'd0, 1'b0};
        tbl[13] = '{1'b0, 3'b111, 1'b0, 3'b010, 1'b1, DR, 17'd0, 1'b0};
        tbl[14] = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b1, DR, 17'd0, 1'b0};
        tbl[15] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b1, DG, 17'd1, 1'b0};
        tbl[16] = '{1'b0, 3'b111, 1'b1, 3'b001, 1'b1, DB, 17'd2, 1'b0};
        tbl[17] = '{1'b0, 3'b111, 1'b1, 3'b100, 1'b1, DR, 17'd3, 1'b0};

        for (int i = 0; i < 18; i++) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].rts, 1'b0, tbl[i].ortr, DR, DG, DB, seen);
            chk($sformatf("tbl%0d_rtr", i), {61'd0, seen}, {61'd0, tbl[i].ertr});
            chk($sformatf("tbl%0d_out", i), {out_rts, frame_done, out_data, 13'd0, mem_ptr},
                {tbl[i].eors, tbl[i].efd, tbl[i].edata, 13'd0, tbl[i].eptr});
        end

        // Restart after 4 accepted words (sel=G, one word buffered).
        do_reset();
        for (int i = 0; i < 4; i++) cycle(3'b111, 1'b0, 1'b1, DR, DG, DB, seen);
        cycle(3'b111, 1'b1, 1'b1, DR, DG, DB, seen);
        chk("restart_rtr_sup", {61'd0, seen}, 64'd0);
        chk("restart_out_rts", {63'd0, out_rts}, 64'd0);
        cycle(3'b100, 1'b0, 1'b1, 32'hAAAA0001, DG, DB, seen);
        chk("restart_r_rtr", {61'd0, seen}, 64'd4);
        chk("restart_ptr", {32'd0, out_data, 15'd0, out_rts, frame_done},
            {32'd0, 32'hAAAA0001, 15'd0, 1'b1, 1'b0});
        chk("restart_ptr0", {47'd0, mem_ptr}, 64'd0);

        // Async reset mid-cycle with a full FIFO.
        do_reset();
        cycle(3'b111, 1'b0, 1'b0, DR, DG, DB, seen);
        cycle(3'b111, 1'b0, 1'b0, DR, DG, DB, seen);
        chk("full_rtr", {61'd0, r_rtr, g_rtr, b_rtr}, 64'd0);
        #2;
        rst_ = 1'b0;
        #1;
        chk("async_out_rts", {63'd0, out_rts}, 64'd0);
        chk("async_mem_ptr", {47'd0, mem_ptr}, 64'd0);
        chk("async_r_rtr", {63'd0, r_rtr}, 64'd1);
        model_reset();
        @(negedge clk);
        rst_ = 1'b1;

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(3'($urandom_range(0, 7)),
                  ($urandom_range(0, 19) == 0),
                  ($urandom_range(0, 3) != 0),
                  $urandom, $urandom, $urandom, seen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
